microwave_timer: RTL

Cook-time keypad and countdown timer that drives the oven controller's start/finish inputs and consumes its heat/bell outputs. It holds a BCD time MM:SS and issues a start pulse on user request. It counts down only while the controller reports heat, then holds finish until the controller raises bell. It sits beside the door/heat/light/bell controller FSM and also feeds the time display.

---
 rtl/microwave_timer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/microwave_timer.sv
// Cook-time keypad and BCD MM:SS countdown beside the oven controller FSM.
// Optional build macro QUICK_START_EN: start from IDLE loads 00:30 and runs.
module microwave_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MAX_MIN       = 99
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       door,
    input  logic       heat,
    input  logic       bell,
    input  logic       btn_add_min,
    input  logic       btn_add_10s,
    input  logic       btn_clear,
    input  logic       btn_start,
    output logic       start,
    output logic       finish,
    output logic       running,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);
    // state | meaning
    // IDLE  | time 00:00, waiting for keypad
    // SET   | nonzero time loaded, waiting for start
    // RUN   | counting down while heat is reported
    // DONE  | finish held until bell, then wait for bell release
    typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_t;

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   time_q;
    logic          start_q, finish_q, running_q;

    logic [3:0]    mt, mo, st, so;
    logic [6:0]    min_val;
    logic          min_at_max;
    logic [7:0]    min_inc;
    logic [15:0]   add_min_d, add_10s_d, dec_d;

    assign {mt, mo, st, so} = time_q;
    assign min_val    = 7'(mt) * 7'd10 + 7'(mo);
    assign min_at_max = (min_val >= 7'(MAX_MIN));

    always_comb begin
        min_inc   = (mo == 4'd9) ? {mt + 4'd1, 4'd0} : {mt, mo + 4'd1};
        add_min_d = min_at_max ? time_q : {min_inc, st, so};
        add_10s_d = {mt, mo, st + 4'd1, so};
        if (st == 4'd5) begin
            // At the minute ceiling the seconds pin to :59 instead of carrying.
            add_10s_d = min_at_max ? {mt, mo, 4'd5, 4'd9} : {min_inc, 4'd0, so};
        end
        dec_d = time_q;
        if (so != 4'd0) begin
            dec_d[3:0] = so - 4'd1;
        end else begin
            dec_d[3:0] = 4'd9;
            if (st != 4'd0) begin
                dec_d[7:4] = st - 4'd1;
            end else begin
                dec_d[7:4] = 4'd5;
                if (mo != 4'd0) begin
                    dec_d[11:8] = mo - 4'd1;
                end else begin
                    dec_d[11:8]  = 4'd9;
                    dec_d[15:12] = mt - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            time_q    <= '0;
            start_q   <= 1'b0;
            finish_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE, SET: begin
                    if (btn_clear) begin
                        time_q  <= '0;
                        state_q <= IDLE;
                    end else if (btn_start) begin
                        // A start pulse always swallows same-cycle add pulses.
                        if (state_q == SET && !door) begin
                            start_q   <= 1'b1;
                            presc_q   <= '0;
                            running_q <= 1'b1;
                            state_q   <= RUN;
                        end
`ifdef QUICK_START_EN
                        else if (state_q == IDLE && !door) begin
                            time_q    <= 16'h0030;
                            start_q   <= 1'b1;
                            presc_q   <= '0;
                            running_q <= 1'b1;
                            state_q   <= RUN;
                        end
`endif
                    end else if (btn_add_min) begin
                        time_q <= add_min_d;
                        if (add_min_d != 16'h0000) state_q <= SET;
                    end else if (btn_add_10s) begin
                        time_q <= add_10s_d;
                        if (add_10s_d != 16'h0000) state_q <= SET;
                    end
                end
                RUN: begin
                    if (heat) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            time_q  <= dec_d;
                            if (dec_d == 16'h0000) begin
                                finish_q <= 1'b1;
                                state_q  <= DONE;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (finish_q) begin
                        if (bell) finish_q <= 1'b0;
                    end else if (!bell) begin
                        running_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start    = start_q;
    assign finish   = finish_q;
    assign running  = running_q;
    assign min_tens = mt;
    assign min_ones = mo;
    assign sec_tens = st;
    assign sec_ones = so;
endmodule
